alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback_pkg.sv | 30 +++
 rtl/alu_writeback_if.sv | 42 ++++
 rtl/alu_writeback_fifo.sv | 50 +++++
 rtl/alu_writeback.sv | 123 ++++++++++++
 tb/tb_alu_writeback.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg -- shared types for the ALU writeback stage.
//   alu_op     : ALU operation encoding (branch compares are LT..NE)
//   wb_entry_t : one buffered ALU result (op, rd, result, pc, offset)
//   wb_state_e : writeback control state (RUN / FLUSH)
//   is_branch  : true for the compare ops that resolve a branch
package alu_writeback_pkg;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
      OP_SLT, OP_SLTU, OP_LT, OP_LTU, OP_GE, OP_GEU, OP_EQ, OP_NE
   } alu_op;

   typedef struct packed {
      alu_op       op;
      logic [4:0]  rd;
      logic [31:0] result;
      logic [31:0] pc;
      logic [31:0] offset;
   } wb_entry_t;

   typedef enum logic {ST_RUN, ST_FLUSH} wb_state_e;

   function automatic logic is_branch(alu_op op);
      case (op)
         OP_LT, OP_LTU, OP_GE, OP_GEU, OP_EQ, OP_NE: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if -- external bus of the writeback stage (ALU result in,
//   register-file write out, branch resolution out).
//   master : producer / environment side
//   slave  : writeback stage side
// wb_fifo_if -- push/pop bus between the writeback control and its FIFO.
//   master : control side (push, pop, flush, wdata)
//   slave  : storage side (head, full, empty)
interface alu_writeback_if;
   import alu_writeback_pkg::*;
   logic        in_valid;
   logic        in_ready;
   alu_op       in_op;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic [31:0] in_pc;
   logic [31:0] in_offset;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_gnt;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_target;

   modport master (output in_valid, in_op, in_rd, in_result, in_pc, in_offset, rf_gnt,
                   input  in_ready, rf_we, rf_waddr, rf_wdata, br_valid, br_taken, br_target);
   modport slave  (input  in_valid, in_op, in_rd, in_result, in_pc, in_offset, rf_gnt,
                   output in_ready, rf_we, rf_waddr, rf_wdata, br_valid, br_taken, br_target);
endinterface

interface wb_fifo_if;
   logic                        push;
   logic                        pop;
   logic                        flush;
   alu_writeback_pkg::wb_entry_t wdata;
   alu_writeback_pkg::wb_entry_t head;
   logic                        full;
   logic                        empty;

   modport master (output push, pop, flush, wdata, input  head, full, empty);
   modport slave  (input  push, pop, flush, wdata, output head, full, empty);
endinterface

// File: rtl/alu_writeback_fifo.sv
// wb_fifo -- DEPTH-entry circular buffer of writeback entries.
//   clk_i : clock (rising edge)
//   rst_i : synchronous active-high reset, empties the buffer
//   bus   : wb_fifo_if.slave (push/pop/flush in, head/full/empty out)
// flush wins over push/pop and empties the buffer in one edge. The caller
// never pops while empty nor pushes while full.
module wb_fifo
   import alu_writeback_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic      clk_i,
   input logic      rst_i,
   wb_fifo_if.slave bus
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   wb_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;

   // Storage array needs no reset: the count decides what is valid.
   always_ff @(posedge clk_i) begin
      if (bus.push) mem_q[wptr_q] <= bus.wdata;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (bus.push) wptr_q <= wptr_q + 1'b1;
         if (bus.pop)  rptr_q <= rptr_q + 1'b1;
         case ({bus.push, bus.pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.head  = mem_q[rptr_q];
   assign bus.empty = (count_q == '0);
   assign bus.full  = (count_q == FULL_CNT);

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback -- buffers ALU results and retires them either as
// register-file writes or as branch resolutions.
//   req_i, rst_i         : clock (rising edge), synchronous active-high reset
//   in_valid_i/in_ready_o: result handshake; in_op_i, in_rd_i, in_result_i,
//                          in_pc_i, in_offset_i carry the entry
//   rf_we_o, rf_waddr_o, rf_wdata_o, rf_gnt_i : register-file write port
//   br_valid_o, br_taken_o, br_target_o       : branch resolution
//   perf_retired_o, perf_flush_o : only with ALU_WB_PERF_EN defined
// The head entry drives the outputs straight from storage, so a result is
// visible one edge after it is accepted. A taken branch empties the buffer
// and spends one FLUSH cycle refusing new input.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        req_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  alu_op       in_op_i,
   input  logic [4:0]  in_rd_i,
   input  logic [31:0] in_result_i,
   input  logic [31:0] in_pc_i,
   input  logic [31:0] in_offset_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   input  logic        rf_gnt_i,
   output logic        br_valid_o,
   output logic        br_taken_o,
   output logic [31:0] br_target_o
`ifdef ALU_WB_PERF_EN
   ,
   output logic [31:0] perf_retired_o,
   output logic [31:0] perf_flush_o
`endif
);

   wb_state_e state_q, state_d;
   wb_entry_t head;
   logic      head_br, run, push, pop, taken_pop;

   wb_fifo_if fif ();

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i (req_i),
      .rst_i (rst_i),
      .bus   (fif)
   );

   assign head    = fif.head;
   assign head_br = is_branch(head.op);
   // Gating on rst_i keeps every output quiet during the reset cycle itself.
   assign run     = (state_q == ST_RUN) && !rst_i;

   // State register
   always_ff @(posedge req_i) begin
      if (rst_i) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // Next state: FLUSH lasts exactly one cycle
   always_comb begin
      state_d = ST_RUN;
      if (state_q == ST_RUN && taken_pop) state_d = ST_FLUSH;
   end

   // Outputs
   always_comb begin
      in_ready_o  = 1'b0;
      rf_we_o     = 1'b0;
      rf_waddr_o  = '0;
      rf_wdata_o  = '0;
      br_valid_o  = 1'b0;
      br_taken_o  = 1'b0;
      br_target_o = '0;
      if (run) begin
         in_ready_o = !fif.full;
         if (!fif.empty) begin
            if (head_br) begin
               br_valid_o  = 1'b1;
               br_taken_o  = head.result[0];
               br_target_o = head.pc + head.offset;
            end else if (head.rd != 5'd0) begin
               rf_we_o    = 1'b1;
               rf_waddr_o = head.rd;
               rf_wdata_o = head.result;
            end
         end
      end
   end

   assign taken_pop = br_valid_o && br_taken_o;
   // Branches and rd==0 writes leave after one cycle; real writes wait for grant.
   assign pop       = run && !fif.empty && (head_br || head.rd == 5'd0 || rf_gnt_i);
   // An entry accepted alongside a taken branch belongs to the squashed path.
   assign push      = in_valid_i && in_ready_o && !taken_pop;

   assign fif.push  = push;
   assign fif.pop   = pop;
   assign fif.flush = taken_pop;
   assign fif.wdata = '{op: in_op_i, rd: in_rd_i, result: in_result_i,
                        pc: in_pc_i, offset: in_offset_i};

`ifdef ALU_WB_PERF_EN
   logic [31:0] retired_q, flush_q;

   always_ff @(posedge req_i) begin
      if (rst_i) begin
         retired_q <= '0;
         flush_q   <= '0;
      end else begin
         if (pop)       retired_q <= retired_q + 32'd1;
         if (taken_pop) flush_q   <= flush_q + 32'd1;
      end
   end

   assign perf_retired_o = retired_q;
   assign perf_flush_o   = flush_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback -- directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the writeback stage.
module tb_alu_writeback;
   import alu_writeback_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_writeback_if bus ();

`ifdef ALU_WB_PERF_EN
   logic [31:0] perf_ret, perf_fl;
`endif

   alu_writeback #(.DEPTH(DEPTH)) dut (
      .req_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (bus.in_ready),
      .in_op_i     (bus.in_op),
      .in_rd_i     (bus.in_rd),
      .in_result_i (bus.in_result),
      .in_pc_i     (bus.in_pc),
      .in_offset_i (bus.in_offset),
      .rf_we_o     (bus.rf_we),
      .rf_waddr_o  (bus.rf_waddr),
      .rf_wdata_o  (bus.rf_wdata),
      .rf_gnt_i    (bus.rf_gnt),
      .br_valid_o  (bus.br_valid),
      .br_taken_o  (bus.br_taken),
      .br_target_o (bus.br_target)
`ifdef ALU_WB_PERF_EN
      ,
      .perf_retired_o (perf_ret),
      .perf_flush_o   (perf_fl)
`endif
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      alu_op       op;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] pc;
      logic [31:0] off;
   } ent_t;

   ent_t        mq[$];
   bit          m_flush = 1'b0;
   logic        e_ready, e_we, e_bv, e_bt;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata, e_tgt;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic bit brop(alu_op op);
      return op inside {OP_LT, OP_LTU, OP_GE, OP_GEU, OP_EQ, OP_NE};
   endfunction

   function automatic void calc_exp();
      e_ready = 1'b0; e_we = 1'b0; e_bv = 1'b0; e_bt = 1'b0;
      e_waddr = '0;   e_wdata = '0; e_tgt = '0;
      if (rst || m_flush) return;
      e_ready = (mq.size() < DEPTH);
      if (mq.size() == 0) return;
      if (brop(mq[0].op)) begin
         e_bv  = 1'b1;
         e_bt  = mq[0].res[0];
         e_tgt = mq[0].pc + mq[0].off;
      end else if (mq[0].rd != 5'd0) begin
         e_we    = 1'b1;
         e_waddr = mq[0].rd;
         e_wdata = mq[0].res;
      end
   endfunction

   // Advance the model across one rising edge using the pre-edge inputs.
   function automatic void model_edge();
      bit push;
      calc_exp();
      if (rst) begin mq.delete(); m_flush = 1'b0; return; end
      if (m_flush) begin m_flush = 1'b0; return; end
      push = bus.in_valid && e_ready;
      if (e_bv && e_bt) begin mq.delete(); m_flush = 1'b1; return; end
      if (e_bv || (mq.size() > 0 && mq[0].rd == 5'd0) || (e_we && bus.rf_gnt))
         void'(mq.pop_front());
      if (push)
         mq.push_back('{op: bus.in_op, rd: bus.in_rd, res: bus.in_result,
                        pc: bus.in_pc, off: bus.in_offset});
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      calc_exp();
      cmp("in_ready",  32'(bus.in_ready),  32'(e_ready));
      cmp("rf_we",     32'(bus.rf_we),     32'(e_we));
      cmp("rf_waddr",  32'(bus.rf_waddr),  32'(e_waddr));
      cmp("rf_wdata",  bus.rf_wdata,       e_wdata);
      cmp("br_valid",  32'(bus.br_valid),  32'(e_bv));
      cmp("br_taken",  32'(bus.br_taken),  32'(e_bt));
      cmp("br_target", bus.br_target,      e_tgt);
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit v, input alu_op op = OP_ADD, input logic [4:0] rd = 5'd0,
                        input logic [31:0] res = 32'd0, input logic [31:0] pc = 32'd0,
                        input logic [31:0] off = 32'd0);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_rd     = rd;
      bus.in_result = res;
      bus.in_pc     = pc;
      bus.in_offset = off;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] got[$];
      bit         acc;
      bus.rf_gnt = 1'b0;
      drive(1'b0);
      step(); step();
      at_neg();
      cmp("rst_in_ready", 32'(bus.in_ready), 32'd0);
      cmp("rst_rf_we",    32'(bus.rf_we),    32'd0);
      rst = 1'b0;

      // single write, one cycle after acceptance
      bus.rf_gnt = 1'b1;
      drive(1'b1, OP_ADD, 5'd5, 32'h0000_0010);
      step(); drive(1'b0);
      at_neg();
      cmp("add_we",    32'(bus.rf_we),    32'd1);
      cmp("add_waddr", 32'(bus.rf_waddr), 32'd5);
      cmp("add_wdata", bus.rf_wdata,      32'h10);
      step();

      // back-pressure: three writes with no grant, then drain in order
      bus.rf_gnt = 1'b0;
      drive(1'b1, OP_ADD, 5'd1, 32'h11); step();
      drive(1'b1, OP_SUB, 5'd2, 32'h22); step();
      drive(1'b1, OP_OR,  5'd3, 32'h33);
      at_neg();
      cmp("full_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      bus.rf_gnt = 1'b1;
      for (int i = 0; i < 8; i++) begin
         at_neg();
         if (bus.rf_we) got.push_back(bus.rf_waddr);
         acc = bus.in_valid && bus.in_ready;
         step();
         if (acc) drive(1'b0);
      end
      cmp("drain_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
         cmp("drain_order", 32'(got[i]), 32'(i + 1));

      // taken EQ: target wraps to 0xF0, write behind it dropped, one flush cycle
      bus.rf_gnt = 1'b0;
      drive(1'b1, OP_EQ, 5'd0, 32'h1, 32'h100, 32'hFFFF_FFF0); step();
      drive(1'b1, OP_ADD, 5'd4, 32'h44);
      at_neg();
      cmp("eq_valid",  32'(bus.br_valid), 32'd1);
      cmp("eq_taken",  32'(bus.br_taken), 32'd1);
      cmp("eq_target", bus.br_target,     32'h0000_00F0);
      step(); drive(1'b0);
      at_neg();
      cmp("flush_in_ready", 32'(bus.in_ready), 32'd0);
      cmp("flush_rf_we",    32'(bus.rf_we),    32'd0);
      step();
      at_neg();
      cmp("post_flush_ready", 32'(bus.in_ready), 32'd1);
      cmp("post_flush_we",    32'(bus.rf_we),    32'd0);
      step();

      // not-taken LTU: pulse, no flush, next entry issues
      bus.rf_gnt = 1'b1;
      drive(1'b1, OP_LTU, 5'd0, 32'h0, 32'h200, 32'h8); step();
      drive(1'b1, OP_ADD, 5'd9, 32'h99);
      at_neg();
      cmp("ltu_valid",  32'(bus.br_valid), 32'd1);
      cmp("ltu_taken",  32'(bus.br_taken), 32'd0);
      cmp("ltu_target", bus.br_target,     32'h208);
      step(); drive(1'b0);
      at_neg();
      cmp("ltu_no_flush", 32'(bus.in_ready), 32'd1);
      cmp("ltu_next_we",  32'(bus.rf_we),    32'd1);
      cmp("ltu_next_wa",  32'(bus.rf_waddr), 32'd9);
      step();

      // rd==0 write retires without a grant
      bus.rf_gnt = 1'b0;
      drive(1'b1, OP_XOR, 5'd0, 32'h5); step();
      drive(1'b1, OP_ADD, 5'd6, 32'h66);
      at_neg();
      cmp("rd0_we", 32'(bus.rf_we), 32'd0);
      step(); drive(1'b0);
      at_neg();
      cmp("rd0_next_we", 32'(bus.rf_we),    32'd1);
      cmp("rd0_next_wa", 32'(bus.rf_waddr), 32'd6);
      bus.rf_gnt = 1'b1;
      step();

      // reset while full and stalled
      bus.rf_gnt = 1'b0;
      drive(1'b1, OP_ADD, 5'd7, 32'h77); step();
      drive(1'b1, OP_ADD, 5'd8, 32'h88); step();
      drive(1'b0);
      at_neg();
      cmp("prerst_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      step();
      at_neg();
      cmp("inrst_we", 32'(bus.rf_we), 32'd0);
      step();
      rst = 1'b0;
      at_neg();
      cmp("postrst_ready", 32'(bus.in_ready), 32'd1);
      cmp("postrst_we",    32'(bus.rf_we),    32'd0);
      step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 99) == 0);
         bus.rf_gnt = ($urandom_range(0, 2) != 0);
         drive($urandom_range(0, 3) != 0,
               alu_op'(4'($urandom_range(0, 15))),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom(), $urandom(), $urandom());
         step();
      end

      rst = 1'b0;
      drive(1'b0);
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
